// File: rtl/goldilocks_pkg.sv
// Goldilocks field constants and butterfly mode encodings shared across the
// NTT datapath (multiplier, add/sub stage and controller).
package goldilocks_pkg;

    localparam int DW = 64;

    localparam logic [DW-1:0] MOD       = 64'hFFFF_FFFF_0000_0001;
    localparam logic [DW-1:0] MOD_SUB_1 = 64'hFFFF_FFFF_0000_0000;

    localparam logic BF_MODE_CT     = 1'b0;
    localparam logic BF_MODE_BYPASS = 1'b1;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register carrying a valid bit and a data word; every stage
// shifts each cycle so bubbles keep their exact position.
module pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Data is cleared too so the datapath never carries X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        end else begin
            vld_q[0]  <= in_valid;
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/ntt_bf_addsub.sv
// NTT butterfly add/sub stage: aligns x with the multiplier product t and
// emits (x+t) mod p and (x-t) mod p, or passes x and t through in bypass.
module ntt_bf_addsub
    import goldilocks_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int TAG_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_x,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [DW-1:0]    mul_p,
    output logic             out_valid,
    output logic [DW-1:0]    out_sum,
    output logic [DW-1:0]    out_diff,
    output logic [TAG_W-1:0] out_tag
);

    localparam int DLY_W = DW + 1 + TAG_W;

    function automatic logic [DW-1:0] reduce_sum(input logic [DW:0] s);
        logic [DW:0] m;
        logic [DW:0] r;
        m = {1'b0, MOD};
        r = s - m;
        return (s >= m) ? r[DW-1:0] : s[DW-1:0];
    endfunction

    // Bit DW is the borrow; adding MOD wraps modulo 2^64 back into range.
    function automatic logic [DW-1:0] reduce_diff(input logic [DW:0] d);
        logic [DW-1:0] r;
        r = d[DW-1:0] + MOD;
        return d[DW] ? r : d[DW-1:0];
    endfunction

    logic             vld_p0;
    logic [DLY_W-1:0] dly_p0;
    logic [DW-1:0]    x_p0;
    logic             mode_p0;
    logic [TAG_W-1:0] tag_p0;

    logic             vld_p1;
    logic [DW:0]      sum_raw_p1;
    logic [DW:0]      diff_raw_p1;
    logic             mode_p1;
    logic [TAG_W-1:0] tag_p1;

    // Stage D: align x/mode/tag with the multiplier output
    pipe_delay #(
        .WIDTH (DLY_W),
        .DEPTH (MUL_LAT)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   ({in_x, in_mode, in_tag}),
        .out_valid (vld_p0),
        .out_data  (dly_p0)
    );

    assign {x_p0, mode_p0, tag_p0} = dly_p0;

    // Stage A: raw 65-bit sum and difference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            sum_raw_p1  <= '0;
            diff_raw_p1 <= '0;
            mode_p1     <= BF_MODE_CT;
            tag_p1      <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                mode_p1 <= mode_p0;
                tag_p1  <= tag_p0;
                if (mode_p0 == BF_MODE_BYPASS) begin
                    sum_raw_p1  <= {1'b0, x_p0};
                    diff_raw_p1 <= {1'b0, mul_p};
                end else begin
                    sum_raw_p1  <= {1'b0, x_p0} + {1'b0, mul_p};
                    diff_raw_p1 <= {1'b0, x_p0} - {1'b0, mul_p};
                end
            end
        end
    end

    // Stage B: modular correction into the output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_diff  <= '0;
            out_tag   <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out_tag <= tag_p1;
                if (mode_p1 == BF_MODE_BYPASS) begin
                    out_sum  <= sum_raw_p1[DW-1:0];
                    out_diff <= diff_raw_p1[DW-1:0];
                end else begin
                    out_sum  <= reduce_sum(sum_raw_p1);
                    out_diff <= reduce_diff(diff_raw_p1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_bf_addsub.sv
// Directed-table and streaming bench for ntt_bf_addsub with a cycle model
// that replays the multiplier product MUL_LAT cycles after each operand.
module tb_ntt_bf_addsub;

    localparam int MUL_LAT = 4;
    localparam int TAG_W   = 12;
    localparam logic [63:0] MOD  = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] MODM1 = 64'hFFFF_FFFF_0000_0000;
    localparam logic [63:0] MODM2 = 64'hFFFF_FFFE_FFFF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [63:0]      in_x = '0;
    logic             in_mode = 1'b0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [63:0]      mul_p = '0;
    logic             out_valid;
    logic [63:0]      out_sum;
    logic [63:0]      out_diff;
    logic [TAG_W-1:0] out_tag;

    ntt_bf_addsub #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_diff  (out_diff),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Operands must always be canonical.
    always @(negedge clk) begin
        if (in_valid) assert (in_x < MOD) else $error("non-canonical x");
        assert (mul_p < MOD) else $error("non-canonical t");
    end

    typedef struct {
        logic [63:0]      x;
        logic [63:0]      t;
        logic             mode;
        logic [TAG_W-1:0] tag;
        logic [63:0]      es;
        logic [63:0]      ed;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic             hv   [8];
    logic [63:0]      hx   [8];
    logic [63:0]      ht   [8];
    logic             hm   [8];
    logic [TAG_W-1:0] htag [8];
    logic [63:0]      exp_sum, exp_diff;
    logic [TAG_W-1:0] exp_tag;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endfunction

    function automatic logic [63:0] rand_canon();
        logic [63:0] r;
        logic [63:0] corners [6];
        corners = '{64'd0, 64'd1, MODM1, MODM2, 64'h1_0000_0000, 64'hFFFF_FFFF};
        if ($urandom_range(3) == 0) return corners[$urandom_range(5)];
        r = {$urandom, $urandom};
        if (r >= MOD) r = r - MOD;
        return r;
    endfunction

    function automatic logic [63:0] model_sum(input logic [63:0] x, input logic [63:0] t, input logic m);
        logic [127:0] s;
        if (m) return x;
        s = ({64'd0, x} + {64'd0, t}) % {64'd0, MOD};
        return s[63:0];
    endfunction

    function automatic logic [63:0] model_diff(input logic [63:0] x, input logic [63:0] t, input logic m);
        logic [127:0] d;
        if (m) return t;
        d = ({64'd0, x} + {64'd0, MOD} - {64'd0, t}) % {64'd0, MOD};
        return d[63:0];
    endfunction

    task automatic tick(input logic v, input logic [63:0] x, input logic m,
                        input logic [TAG_W-1:0] tg, input logic [63:0] t);
        int i4, i5;
        hv[cyc & 7] = v; hx[cyc & 7] = x; ht[cyc & 7] = t;
        hm[cyc & 7] = m; htag[cyc & 7] = tg;
        in_valid = v; in_x = x; in_mode = m; in_tag = tg;
        i4 = (cyc - MUL_LAT) & 7;
        mul_p = hv[i4] ? ht[i4] : rand_canon();
        @(posedge clk);
        #1;
        i5 = (cyc - (MUL_LAT + 1)) & 7;
        if (hv[i5]) begin
            exp_sum  = model_sum(hx[i5], ht[i5], hm[i5]);
            exp_diff = model_diff(hx[i5], ht[i5], hm[i5]);
            exp_tag  = htag[i5];
        end
        chk("valid", {63'd0, out_valid}, {63'd0, hv[i5]});
        chk("sum",   out_sum,  exp_sum);
        chk("diff",  out_diff, exp_diff);
        chk("tag",   {52'd0, out_tag}, {52'd0, exp_tag});
        cyc++;
    endtask

    task automatic bubble();
        tick(1'b0, 64'd0, 1'b0, '0, 64'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum",   out_sum,  64'd0);
        chk("rst_diff",  out_diff, 64'd0);
        chk("rst_tag",   {52'd0, out_tag}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) hv[i] = 1'b0;
        exp_sum = '0; exp_diff = '0; exp_tag = '0;
        cyc++;
    endtask

    vec_t tab [10];
    logic [7:0] pat;

    initial begin
        for (int i = 0; i < 8; i++) begin
            hv[i] = 1'b0; hx[i] = '0; ht[i] = '0; hm[i] = 1'b0; htag[i] = '0;
        end
        exp_sum = '0; exp_diff = '0; exp_tag = '0;

        tab[0] = '{64'd5, 64'd3, 1'b0, 12'h101, 64'd8, 64'd2};
        tab[1] = '{64'd3, 64'd5, 1'b0, 12'h102, 64'd8, MODM2};
        tab[2] = '{MODM1, MODM1, 1'b0, 12'h103, MODM2, 64'd0};
        tab[3] = '{MODM1, 64'd1, 1'b0, 12'h104, 64'd0, MODM2};
        tab[4] = '{64'd0, 64'd1, 1'b0, 12'h105, 64'd1, MODM1};
        tab[5] = '{64'h1_0000_0000, 64'hFFFF_FFFF, 1'b0, 12'h106, 64'h1_FFFF_FFFF, 64'd1};
        tab[6] = '{64'd0, 64'd0, 1'b0, 12'h107, 64'd0, 64'd0};
        tab[7] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0, 12'h108,
                   64'h0246_8ACF_1357_9BDE, 64'd0};
        tab[8] = '{64'd123, MODM1, 1'b1, 12'h109, 64'd123, MODM1};
        tab[9] = '{MODM1, 64'd7, 1'b1, 12'hABC, MODM1, 64'd7};

        #3;
        do_reset();

        // Directed table: one operand, then check it 6 cycles later.
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, tab[k].x, tab[k].mode, tab[k].tag, tab[k].t);
            for (int j = 0; j < MUL_LAT + 1; j++) bubble();
            chk("tab_valid", {63'd0, out_valid}, 64'd1);
            chk("tab_sum",   out_sum,  tab[k].es);
            chk("tab_diff",  out_diff, tab[k].ed);
            chk("tab_tag",   {52'd0, out_tag}, {52'd0, tab[k].tag});
            bubble();
            chk("tab_hold_sum", out_sum, tab[k].es);
        end

        // 32-item stream with gappy valid pattern 1101_0011 and mixed modes.
        pat = 8'b1101_0011;
        begin
            int item = 0;
            int c = 0;
            while (item < 32) begin
                if (pat[7 - (c % 8)]) begin
                    tick(1'b1, rand_canon(), (item % 3) == 2, item[TAG_W-1:0], rand_canon());
                    item++;
                end else begin
                    bubble();
                end
                c++;
            end
        end
        for (int j = 0; j < 8; j++) bubble();

        // Reset mid-stream with five items in flight.
        for (int k = 0; k < 5; k++)
            tick(1'b1, 64'd1000 + k, 1'b0, 12'h200 + k[TAG_W-1:0], 64'd10);
        do_reset();
        for (int j = 0; j < 10; j++) bubble();
        tick(1'b1, 64'd40, 1'b0, 12'h3EE, 64'd2);
        for (int j = 0; j < MUL_LAT; j++) bubble();
        chk("post_rst_early", {63'd0, out_valid}, 64'd0);
        bubble();
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_sum",   out_sum,  64'd42);
        chk("post_rst_diff",  out_diff, 64'd38);
        chk("post_rst_tag",   {52'd0, out_tag}, 64'h3EE);

        // Random canonical operands, mostly back-to-back.
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(7) == 0) bubble();
            else tick(1'b1, rand_canon(), $urandom_range(7) == 0,
                      TAG_W'($urandom), rand_canon());
        end
        for (int j = 0; j < 8; j++) bubble();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
